pwm_ramp_sequencer: RTL

PWM_RAMP_SEQUENCER -- requirements
Module: pwm_ramp_sequencer

---
 rtl/pwm_ramp_pkg.sv | 79 +++++++
 rtl/pwm_ramp_timer.sv | 32 +++
 rtl/pwm_ramp_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pwm_ramp_pkg.sv
// Shared types and constants for the PWM ramp sequencer.
// Holds the FSM state encoding, the config slave word map and CTRL/STAT
// bit positions, the downstream PWM slave word map, the reset constants,
// the master write payload struct and small arithmetic helpers.
package pwm_ramp_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CALC  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    // Config slave word addresses
    localparam logic [ADDR_W-1:0] CFG_TARGET   = 2'd0;
    localparam logic [ADDR_W-1:0] CFG_STEP     = 2'd1;
    localparam logic [ADDR_W-1:0] CFG_INTERVAL = 2'd2;
    localparam logic [ADDR_W-1:0] CFG_CTRL     = 2'd3;

    // CTRL/STAT bit positions
    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_ABORT  = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;
    localparam int unsigned STAT_BUSY   = 8;
    localparam int unsigned STAT_DONE   = 9;

    // Downstream PWM slave word map
    typedef enum logic [ADDR_W-1:0] {
        PWM_PW     = 2'd0,
        PWM_PERIOD = 2'd1,
        PWM_ENABLE = 2'd2
    } pwm_reg_e;

    // Reset constants
    localparam int unsigned       PW_RESET_DEF       = 250000;
    localparam int unsigned       INTERVAL_RESET_DEF = 50000;
    localparam logic [DATA_W-1:0] STEP_RESET         = 32'd1;

    // Master write payload
    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [BE_W-1:0]   byteenable;
        logic [DATA_W-1:0] writedata;
    } avm_req_t;

    // One ramp step toward target; clamps at target so it never overshoots or wraps.
    function automatic logic [DATA_W-1:0] calc_next(input logic [DATA_W-1:0] cur,
                                                    input logic [DATA_W-1:0] target,
                                                    input logic [DATA_W-1:0] step);
        logic [DATA_W-1:0] step_eff;
        logic [DATA_W-1:0] res;
        step_eff = (step == '0) ? DATA_W'(1) : step;
        if (cur < target) begin
            res = ((target - cur) <= step_eff) ? target : cur + step_eff;
        end else if (cur > target) begin
            res = ((cur - target) <= step_eff) ? target : cur - step_eff;
        end else begin
            res = cur;
        end
        return res;
    endfunction

    // Byte-lane merge of a write into an existing register value.
    function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0] old_val,
                                                   input logic [DATA_W-1:0] new_val,
                                                   input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int i = 0; i < int'(BE_W); i++) begin
            if (be[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_ramp_timer.sv
// Interval down-counter for the ramp sequencer.
// Ports: csi_clk/rsi_rst clock and async active-high reset; load/load_value
// restart the count (0 is treated as 1); enable decrements once per cycle;
// expire (registered) is high while the count reads 1.
module pwm_ramp_timer
    import pwm_ramp_pkg::*;
(
    input  logic              csi_clk,
    input  logic              rsi_rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_value,
    input  logic              enable,
    output logic              expire
);

    logic [DATA_W-1:0] count_q;

    // expire is registered alongside the count so it mirrors (count_q == 1)
    always_ff @(posedge csi_clk or posedge rsi_rst) begin
        if (rsi_rst) begin
            count_q <= '0;
            expire  <= 1'b0;
        end else if (load) begin
            count_q <= (load_value == '0) ? DATA_W'(1) : load_value;
            expire  <= (load_value <= DATA_W'(1));
        end else if (enable && (count_q != '0)) begin
            count_q <= count_q - DATA_W'(1);
            expire  <= (count_q == DATA_W'(2));
        end
    end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// PWM pulse-width ramp sequencer.
// A config slave (avs_s0_*) holds TARGET, STEP, INTERVAL and CTRL/STAT.
// On START the block steps its tracked pulse width toward TARGET, writing
// each intermediate value to a PWM slave through a master port (avm_m0_*)
// every INTERVAL cycles. ins_irq is a level interrupt for DONE & IRQ_EN.
module pwm_ramp_sequencer
    import pwm_ramp_pkg::*;
#(
    parameter int unsigned PW_RESET       = PW_RESET_DEF,
    parameter int unsigned INTERVAL_RESET = INTERVAL_RESET_DEF
) (
    input  logic              csi_clk,
    input  logic              rsi_rst,
    input  logic              avs_s0_chip_select,
    input  logic              avs_s0_read,
    input  logic              avs_s0_write,
    input  logic [ADDR_W-1:0] avs_s0_address,
    input  logic [BE_W-1:0]   avs_s0_byteenable,
    input  logic [DATA_W-1:0] avs_s0_writedata,
    output logic [DATA_W-1:0] avs_s0_readdata,
    output logic [ADDR_W-1:0] avm_m0_address,
    output logic              avm_m0_write,
    output logic [BE_W-1:0]   avm_m0_byteenable,
    output logic [DATA_W-1:0] avm_m0_writedata,
    input  logic              avm_m0_waitrequest,
    output logic              ins_irq
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] cur_q, cur_d;
    logic [DATA_W-1:0] target_q, step_q, interval_q;
    logic              irq_en_q, irq_en_d;
    logic              done_q, done_d;
    logic              abort_pend_q, abort_pend_d;
    avm_req_t          avm_q, avm_d;
    logic              avm_write_q, avm_write_d;
    logic [DATA_W-1:0] readdata_q, rd_word;
    logic              ins_irq_q;

    logic cfg_wr, cfg_rd, ctrl_wr0;
    logic start_req, abort_req, done_clr;
    logic done_set, done_start_clr;
    logic tmr_load, tmr_en, tmr_expire;

    // Config slave decode; CTRL pulses need lane 0, DONE clear needs lane 1
    always_comb begin
        cfg_wr    = avs_s0_chip_select && avs_s0_write;
        cfg_rd    = avs_s0_chip_select && avs_s0_read;
        ctrl_wr0  = cfg_wr && (avs_s0_address == CFG_CTRL) && avs_s0_byteenable[0];
        start_req = ctrl_wr0 && avs_s0_writedata[CTRL_START];
        abort_req = ctrl_wr0 && avs_s0_writedata[CTRL_ABORT];
        done_clr  = cfg_wr && (avs_s0_address == CFG_CTRL) && avs_s0_byteenable[1]
                    && avs_s0_writedata[STAT_DONE];
        irq_en_d  = ctrl_wr0 ? avs_s0_writedata[CTRL_IRQ_EN] : irq_en_q;
    end

    // Read mux; reserved bits read as zero
    always_comb begin
        rd_word = '0;
        case (avs_s0_address)
            CFG_TARGET:   rd_word = target_q;
            CFG_STEP:     rd_word = step_q;
            CFG_INTERVAL: rd_word = interval_q;
            default: begin
                rd_word[CTRL_IRQ_EN] = irq_en_q;
                rd_word[STAT_BUSY]   = (state_q != ST_IDLE);
                rd_word[STAT_DONE]   = done_q;
            end
        endcase
    end

    // Next-state and master-port logic
    always_comb begin
        state_d        = state_q;
        cur_d          = cur_q;
        avm_d          = avm_q;
        avm_write_d    = 1'b0;
        abort_pend_d   = abort_pend_q;
        done_set       = 1'b0;
        done_start_clr = 1'b0;
        tmr_load       = 1'b0;
        tmr_en         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                abort_pend_d = 1'b0;
                if (start_req && !abort_req) begin
                    if (cur_q == target_q) begin
                        done_set = 1'b1;
                    end else begin
                        done_start_clr = 1'b1;
                        tmr_load       = 1'b1;
                        state_d        = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                tmr_en = 1'b1;
                if (abort_req) begin
                    state_d = ST_IDLE;
                end else if (tmr_expire) begin
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (abort_req) begin
                    state_d = ST_IDLE;
                end else begin
                    avm_d.address    = ADDR_W'(PWM_PW);
                    avm_d.byteenable = '1;
                    avm_d.writedata  = calc_next(cur_q, target_q, step_q);
                    avm_write_d      = 1'b1;
                    state_d          = ST_WRITE;
                end
            end
            ST_WRITE: begin
                avm_write_d = 1'b1;
                if (abort_req) abort_pend_d = 1'b1;
                // An abort during the transfer is remembered until it completes
                if (!avm_m0_waitrequest) begin
                    avm_write_d = 1'b0;
                    cur_d       = avm_q.writedata;
                    if (abort_pend_q || abort_req) begin
                        abort_pend_d = 1'b0;
                        state_d      = ST_IDLE;
                    end else if (avm_q.writedata == target_q) begin
                        done_set = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        tmr_load = 1'b1;
                        state_d  = ST_WAIT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A completion setting DONE takes priority over a same-cycle clear
        if (done_set) begin
            done_d = 1'b1;
        end else if (done_start_clr || done_clr) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end
    end

    // FSM, tracked pulse width and master port registers
    always_ff @(posedge csi_clk or posedge rsi_rst) begin
        if (rsi_rst) begin
            state_q      <= ST_IDLE;
            cur_q        <= DATA_W'(PW_RESET);
            avm_q        <= '0;
            avm_write_q  <= 1'b0;
            abort_pend_q <= 1'b0;
            done_q       <= 1'b0;
            irq_en_q     <= 1'b0;
            ins_irq_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            avm_q        <= avm_d;
            avm_write_q  <= avm_write_d;
            abort_pend_q <= abort_pend_d;
            done_q       <= done_d;
            irq_en_q     <= irq_en_d;
            ins_irq_q    <= done_d && irq_en_d;
        end
    end

    // Config registers and registered read data
    always_ff @(posedge csi_clk or posedge rsi_rst) begin
        if (rsi_rst) begin
            target_q   <= DATA_W'(PW_RESET);
            step_q     <= STEP_RESET;
            interval_q <= DATA_W'(INTERVAL_RESET);
            readdata_q <= '0;
        end else begin
            if (cfg_wr) begin
                case (avs_s0_address)
                    CFG_TARGET:   target_q   <= be_merge(target_q, avs_s0_writedata, avs_s0_byteenable);
                    CFG_STEP:     step_q     <= be_merge(step_q, avs_s0_writedata, avs_s0_byteenable);
                    CFG_INTERVAL: interval_q <= be_merge(interval_q, avs_s0_writedata, avs_s0_byteenable);
                    default: ;
                endcase
            end
            if (cfg_rd) readdata_q <= rd_word;
        end
    end

    pwm_ramp_timer u_timer (
        .csi_clk    (csi_clk),
        .rsi_rst    (rsi_rst),
        .load       (tmr_load),
        .load_value (interval_q),
        .enable     (tmr_en),
        .expire     (tmr_expire)
    );

    assign avs_s0_readdata   = readdata_q;
    assign avm_m0_address    = avm_q.address;
    assign avm_m0_write      = avm_write_q;
    assign avm_m0_byteenable = avm_q.byteenable;
    assign avm_m0_writedata  = avm_q.writedata;
    assign ins_irq           = ins_irq_q;

endmodule
